// File: rtl/control_unit_if.sv
// Control bundle between the control_unit sequencer and the datapath.
// Mem_ready exists only when MEM_WAIT_EN is defined.
interface control_unit_if;
    logic [31:0] IR;
    logic        CON_ff;
`ifdef MEM_WAIT_EN
    logic        Mem_ready;
`endif
    logic PCout, ZLowout, ZHighout, MDRout;
    logic Yout, HIout, LOout, InPortout;
    logic BAout, Cout, R_out;
    logic PC_enable, IncPC, MAR_enable;
    logic MDR_enable, MDR_read, IR_enable;
    logic Y_enable, ZLowIn, ZHighIn;
    logic HI_enable, LO_enable, OutPort_enable;
    logic CONin, R_in;
    logic Gra, Grb, Grc;
    logic RAM_write;
    logic [3:0] ALU_op;
    logic Run;

    modport master (
`ifdef MEM_WAIT_EN
        input  Mem_ready,
`endif
        input  IR, CON_ff,
        output PCout, ZLowout, ZHighout, MDRout,
        output Yout, HIout, LOout, InPortout,
        output BAout, Cout, R_out,
        output PC_enable, IncPC, MAR_enable,
        output MDR_enable, MDR_read, IR_enable,
        output Y_enable, ZLowIn, ZHighIn,
        output HI_enable, LO_enable, OutPort_enable,
        output CONin, R_in,
        output Gra, Grb, Grc,
        output RAM_write, ALU_op, Run
    );

    modport slave (
`ifdef MEM_WAIT_EN
        output Mem_ready,
`endif
        output IR, CON_ff,
        input  PCout, ZLowout, ZHighout, MDRout,
        input  Yout, HIout, LOout, InPortout,
        input  BAout, Cout, R_out,
        input  PC_enable, IncPC, MAR_enable,
        input  MDR_enable, MDR_read, IR_enable,
        input  Y_enable, ZLowIn, ZHighIn,
        input  HI_enable, LO_enable, OutPort_enable,
        input  CONin, R_in,
        input  Gra, Grb, Grc,
        input  RAM_write, ALU_op, Run
    );
endinterface

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: fetch T0-T2, per-class execute T3-T7.
// Define MEM_WAIT_EN to stall T1, ld T6 and st T7 on Mem_ready.
module control_unit (
    input logic Clock,
    input logic Clear,
    control_unit_if.master bus
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3,
        S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        K_NOP, K_LD, K_ST, K_ALU, K_IMM,
        K_BR, K_JR, K_JAL, K_HALT
    } kind_t;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] opcode;
    kind_t      kind;
    logic [3:0] alu_sel;
    logic       mem_ready;
    logic       unused_ir;

    assign unused_ir = ^bus.IR[26:0];

`ifdef MEM_WAIT_EN
    assign mem_ready = bus.Mem_ready;
`else
    assign mem_ready = 1'b1;
`endif

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state  <= S_RESET;
            opcode <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_T2)
                opcode <= bus.IR[31:27];
        end
    end

    always_comb begin
        kind    = K_NOP;
        alu_sel = 4'd0;
        case (opcode)
            5'b00000: kind = K_LD;
            5'b00010: kind = K_ST;
            5'b00011: begin kind = K_ALU; alu_sel = 4'd0; end
            5'b00100: begin kind = K_ALU; alu_sel = 4'd1; end
            5'b00101: begin kind = K_ALU; alu_sel = 4'd2; end
            5'b00110: begin kind = K_ALU; alu_sel = 4'd3; end
            5'b01011: begin kind = K_IMM; alu_sel = 4'd0; end
            5'b01100: begin kind = K_IMM; alu_sel = 4'd2; end
            5'b01101: begin kind = K_IMM; alu_sel = 4'd3; end
            5'b10010: kind = K_BR;
            5'b10011: kind = K_JR;
            5'b10100: kind = K_JAL;
            5'b11011: kind = K_HALT;
            default:  kind = K_NOP;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET: state_nxt = S_T0;
            S_T0:    state_nxt = S_T1;
            S_T1:    if (mem_ready) state_nxt = S_T2;
            S_T2:    state_nxt = S_T3;
            S_T3: begin
                case (kind)
                    K_JR, K_NOP: state_nxt = S_T0;
                    K_HALT:      state_nxt = S_HALT;
                    default:     state_nxt = S_T4;
                endcase
            end
            S_T4: begin
                case (kind)
                    K_ALU, K_IMM, K_LD, K_ST, K_BR: state_nxt = S_T5;
                    default:                        state_nxt = S_T0;
                endcase
            end
            S_T5: begin
                case (kind)
                    K_LD, K_ST, K_BR: state_nxt = S_T6;
                    default:          state_nxt = S_T0;
                endcase
            end
            S_T6: begin
                case (kind)
                    K_LD:    if (mem_ready) state_nxt = S_T7;
                    K_ST:    state_nxt = S_T7;
                    default: state_nxt = S_T0;
                endcase
            end
            S_T7: begin
                if (kind != K_ST || mem_ready)
                    state_nxt = S_T0;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_RESET;
        endcase
    end

    always_comb begin
        bus.PCout          = 1'b0;
        bus.ZLowout        = 1'b0;
        bus.ZHighout       = 1'b0;
        bus.MDRout         = 1'b0;
        bus.Yout           = 1'b0;
        bus.HIout          = 1'b0;
        bus.LOout          = 1'b0;
        bus.InPortout      = 1'b0;
        bus.BAout          = 1'b0;
        bus.Cout           = 1'b0;
        bus.R_out          = 1'b0;
        bus.PC_enable      = 1'b0;
        bus.IncPC          = 1'b0;
        bus.MAR_enable     = 1'b0;
        bus.MDR_enable     = 1'b0;
        bus.MDR_read       = 1'b0;
        bus.IR_enable      = 1'b0;
        bus.Y_enable       = 1'b0;
        bus.ZLowIn         = 1'b0;
        bus.ZHighIn        = 1'b0;
        bus.HI_enable      = 1'b0;
        bus.LO_enable      = 1'b0;
        bus.OutPort_enable = 1'b0;
        bus.CONin          = 1'b0;
        bus.R_in           = 1'b0;
        bus.Gra            = 1'b0;
        bus.Grb            = 1'b0;
        bus.Grc            = 1'b0;
        bus.RAM_write      = 1'b0;
        bus.ALU_op         = 4'd0;
        bus.Run            = (state != S_RESET) && (state != S_HALT);
        case (state)
            S_T0: begin
                bus.PCout      = 1'b1;
                bus.MAR_enable = 1'b1;
                bus.IncPC      = 1'b1;
                bus.ZLowIn     = 1'b1;
            end
            S_T1: begin
                bus.ZLowout    = 1'b1;
                bus.PC_enable  = 1'b1;
                bus.MDR_read   = 1'b1;
                bus.MDR_enable = 1'b1;
            end
            S_T2: begin
                bus.MDRout    = 1'b1;
                bus.IR_enable = 1'b1;
            end
            S_T3: begin
                case (kind)
                    K_ALU, K_IMM: begin
                        bus.Grb      = 1'b1;
                        bus.R_out    = 1'b1;
                        bus.Y_enable = 1'b1;
                    end
                    K_LD, K_ST: begin
                        bus.Grb      = 1'b1;
                        bus.BAout    = 1'b1;
                        bus.Y_enable = 1'b1;
                    end
                    K_BR: begin
                        bus.Gra   = 1'b1;
                        bus.R_out = 1'b1;
                        bus.CONin = 1'b1;
                    end
                    K_JR: begin
                        bus.Gra       = 1'b1;
                        bus.R_out     = 1'b1;
                        bus.PC_enable = 1'b1;
                    end
                    K_JAL: begin
                        bus.Grb   = 1'b1;
                        bus.R_in  = 1'b1;
                        bus.PCout = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (kind)
                    K_ALU: begin
                        bus.Grc     = 1'b1;
                        bus.R_out   = 1'b1;
                        bus.ALU_op  = alu_sel;
                        bus.ZLowIn  = 1'b1;
                        bus.ZHighIn = 1'b1;
                    end
                    K_IMM: begin
                        bus.Cout    = 1'b1;
                        bus.ALU_op  = alu_sel;
                        bus.ZLowIn  = 1'b1;
                        bus.ZHighIn = 1'b1;
                    end
                    K_LD, K_ST: begin
                        bus.Cout   = 1'b1;
                        bus.ZLowIn = 1'b1;
                    end
                    K_BR: begin
                        bus.PCout    = 1'b1;
                        bus.Y_enable = 1'b1;
                    end
                    K_JAL: begin
                        bus.Gra       = 1'b1;
                        bus.R_out     = 1'b1;
                        bus.PC_enable = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (kind)
                    K_ALU, K_IMM: begin
                        bus.ZLowout = 1'b1;
                        bus.Gra     = 1'b1;
                        bus.R_in    = 1'b1;
                    end
                    K_LD, K_ST: begin
                        bus.ZLowout    = 1'b1;
                        bus.MAR_enable = 1'b1;
                    end
                    K_BR: begin
                        bus.Cout   = 1'b1;
                        bus.ZLowIn = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (kind)
                    K_LD: begin
                        bus.MDR_read   = 1'b1;
                        bus.MDR_enable = 1'b1;
                    end
                    K_ST: begin
                        bus.Gra        = 1'b1;
                        bus.R_out      = 1'b1;
                        bus.MDR_enable = 1'b1;
                    end
                    // branch target commits only when the condition held
                    K_BR: begin
                        bus.ZLowout   = 1'b1;
                        bus.PC_enable = bus.CON_ff;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (kind)
                    K_LD: begin
                        bus.MDRout = 1'b1;
                        bus.Gra    = 1'b1;
                        bus.R_in   = 1'b1;
                    end
                    K_ST: bus.RAM_write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected control words are queued
// per cycle from the instruction set and compared at each falling edge.
module tb_control_unit;

    typedef struct packed {
        logic PCout, ZLowout, ZHighout, MDRout;
        logic Yout, HIout, LOout, InPortout;
        logic BAout, Cout, R_out;
        logic PC_enable, IncPC, MAR_enable;
        logic MDR_enable, MDR_read, IR_enable;
        logic Y_enable, ZLowIn, ZHighIn;
        logic HI_enable, LO_enable, OutPort_enable;
        logic CONin, R_in;
        logic Gra, Grb, Grc;
        logic RAM_write;
        logic [3:0] ALU_op;
        logic Run;
    } cw_t;

    typedef struct {
        string tag;
        cw_t   exp;
        bit    clr;
        bit    mr;
    } ent_t;

    logic clk;
    logic clear;
    int   n_vec;
    int   n_err;
    bit   scramble;
    ent_t sb[$];

    control_unit_if bus();

    control_unit dut (
        .Clock(clk),
        .Clear(clear),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cw_t sample();
        cw_t s;
        s.PCout          = bus.PCout;
        s.ZLowout        = bus.ZLowout;
        s.ZHighout       = bus.ZHighout;
        s.MDRout         = bus.MDRout;
        s.Yout           = bus.Yout;
        s.HIout          = bus.HIout;
        s.LOout          = bus.LOout;
        s.InPortout      = bus.InPortout;
        s.BAout          = bus.BAout;
        s.Cout           = bus.Cout;
        s.R_out          = bus.R_out;
        s.PC_enable      = bus.PC_enable;
        s.IncPC          = bus.IncPC;
        s.MAR_enable     = bus.MAR_enable;
        s.MDR_enable     = bus.MDR_enable;
        s.MDR_read       = bus.MDR_read;
        s.IR_enable      = bus.IR_enable;
        s.Y_enable       = bus.Y_enable;
        s.ZLowIn         = bus.ZLowIn;
        s.ZHighIn        = bus.ZHighIn;
        s.HI_enable      = bus.HI_enable;
        s.LO_enable      = bus.LO_enable;
        s.OutPort_enable = bus.OutPort_enable;
        s.CONin          = bus.CONin;
        s.R_in           = bus.R_in;
        s.Gra            = bus.Gra;
        s.Grb            = bus.Grb;
        s.Grc            = bus.Grc;
        s.RAM_write      = bus.RAM_write;
        s.ALU_op         = bus.ALU_op;
        s.Run            = bus.Run;
        return s;
    endfunction

    task automatic check(input string tag, input cw_t got, input cw_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic cw_t rw();
        cw_t w;
        w = '0;
        w.Run = 1'b1;
        return w;
    endfunction

    task automatic push(input string tag, input cw_t e,
                        input bit clr = 1'b0, input bit mr = 1'b1);
        ent_t x;
        x.tag = tag;
        x.exp = e;
        x.clr = clr;
        x.mr  = mr;
        sb.push_back(x);
    endtask

    task automatic drain();
        ent_t e;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            check(e.tag, sample(), e.exp);
            clear = e.clr;
`ifdef MEM_WAIT_EN
            bus.Mem_ready = e.mr;
`endif
            if (scramble && e.tag == "T3")
                bus.IR = $urandom();
        end
    endtask

    task automatic push_t0();
        cw_t e;
        e = rw();
        e.PCout = 1; e.MAR_enable = 1; e.IncPC = 1; e.ZLowIn = 1;
        push("T0", e);
    endtask

    task automatic push_fetch(input int t1_wait);
        cw_t e;
        push_t0();
        e = rw();
        e.ZLowout = 1; e.PC_enable = 1; e.MDR_read = 1; e.MDR_enable = 1;
        for (int i = 0; i < t1_wait; i++)
            push("T1wait", e, 1'b0, 1'b0);
        push("T1", e);
        e = rw();
        e.MDRout = 1; e.IR_enable = 1;
        push("T2", e);
    endtask

    task automatic push_addr();
        cw_t e;
        e = rw();
        e.Grb = 1; e.BAout = 1; e.Y_enable = 1;
        push("T3", e);
        e = rw();
        e.Cout = 1; e.ZLowIn = 1;
        push("T4", e);
        e = rw();
        e.ZLowout = 1; e.MAR_enable = 1;
        push("T5", e);
    endtask

    task automatic instr(input logic [31:0] ir, input bit con);
        cw_t e;
        logic [4:0] op;
        logic [3:0] a;
        op = ir[31:27];
        bus.IR = ir;
        bus.CON_ff = con;
        push_fetch(0);
        case (op)
            5'b00000: begin
                push_addr();
                e = rw(); e.MDR_read = 1; e.MDR_enable = 1;
                push("ldT6", e);
                e = rw(); e.MDRout = 1; e.Gra = 1; e.R_in = 1;
                push("ldT7", e);
            end
            5'b00010: begin
                push_addr();
                e = rw(); e.Gra = 1; e.R_out = 1; e.MDR_enable = 1;
                push("stT6", e);
                e = rw(); e.RAM_write = 1;
                push("stT7", e);
            end
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b01011, 5'b01100, 5'b01101: begin
                case (op)
                    5'b00100:           a = 4'd1;
                    5'b00101, 5'b01100: a = 4'd2;
                    5'b00110, 5'b01101: a = 4'd3;
                    default:            a = 4'd0;
                endcase
                e = rw(); e.Grb = 1; e.R_out = 1; e.Y_enable = 1;
                push("T3", e);
                e = rw(); e.ALU_op = a; e.ZLowIn = 1; e.ZHighIn = 1;
                if (op[3]) e.Cout = 1;
                else begin e.Grc = 1; e.R_out = 1; end
                push("aluT4", e);
                e = rw(); e.ZLowout = 1; e.Gra = 1; e.R_in = 1;
                push("aluT5", e);
            end
            5'b10010: begin
                e = rw(); e.Gra = 1; e.R_out = 1; e.CONin = 1;
                push("T3", e);
                e = rw(); e.PCout = 1; e.Y_enable = 1;
                push("brT4", e);
                e = rw(); e.Cout = 1; e.ZLowIn = 1;
                push("brT5", e);
                e = rw(); e.ZLowout = 1; e.PC_enable = con;
                push("brT6", e);
            end
            5'b10011: begin
                e = rw(); e.Gra = 1; e.R_out = 1; e.PC_enable = 1;
                push("T3", e);
            end
            5'b10100: begin
                e = rw(); e.Grb = 1; e.R_in = 1; e.PCout = 1;
                push("T3", e);
                e = rw(); e.Gra = 1; e.R_out = 1; e.PC_enable = 1;
                push("jalT4", e);
            end
            5'b11011: begin
                push("T3", rw());
                for (int i = 0; i < 9; i++)
                    push("halt", '0);
                push("halt", '0, 1'b1);
                push("rst", '0);
            end
            default: push("T3", rw());
        endcase
        drain();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        scramble = 1'b0;
        clear = 1'b1;
        bus.IR = '0;
        bus.CON_ff = 1'b0;
`ifdef MEM_WAIT_EN
        bus.Mem_ready = 1'b1;
`endif
        push("rst", '0, 1'b1);
        push("rst", '0, 1'b0);
        drain();

        instr(32'h59080002, 1'b0);
        instr(32'hA1800000, 1'b0);
        instr(32'h91000004, 1'b0);
        instr(32'h91000004, 1'b1);
        instr(32'h18884000, 1'b0);
        instr(32'h20884000, 1'b0);
        instr(32'h28884000, 1'b0);
        instr(32'h30884000, 1'b0);
        instr(32'h60880007, 1'b0);
        instr(32'h68880007, 1'b0);
        instr(32'h00880010, 1'b0);
        instr(32'h10880010, 1'b0);
        instr(32'h98800000, 1'b0);
        instr(32'h08000000, 1'b0);
        instr(32'hF8000000, 1'b0);
        scramble = 1'b1;
        instr(32'h18884000, 1'b0);
        instr(32'h00880010, 1'b0);
        scramble = 1'b0;
        instr(32'hD8000000, 1'b0);
        instr(32'h59080002, 1'b0);

`ifdef MEM_WAIT_EN
        begin
            cw_t e;
            bus.IR = 32'h00880010;
            push_fetch(3);
            push_addr();
            e = rw(); e.MDR_read = 1; e.MDR_enable = 1;
            push("ldT6wait", e, 1'b0, 1'b0);
            push("ldT6wait", e, 1'b1, 1'b0);
            push("rst", '0);
            drain();
            instr(32'h10880010, 1'b0);
        end
`endif

        push_t0();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
